// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the writeback-arbiter entry format and defaults.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // Default number of long-latency FIFO entries
  localparam int WB_DEPTH_DEFAULT = 4;

  // One buffered long-latency result; live=0 marks an entry that must never be written
  typedef struct packed {
    logic     live;
    regbits_t rd;
    word_t    data;
  } wb_entry_t;

  // One-hot decode of a register index into a 32-bit register mask
  function automatic word_t reg_onehot(input regbits_t r);
    word_t m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result FIFO for the writeback arbiter. Exposes the raw entry array,
// an occupancy mask and a per-entry live-clear input so the arbiter can squash
// WAW-superseded results and build the pending-destination mask.
module wb_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  input  logic [DEPTH-1:0]         clr_mask,
  output wb_entry_t                entries [DEPTH],
  output logic [DEPTH-1:0]         occupied,
  output wb_entry_t                head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] rd_ptr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;

  // Pointer and occupancy bookkeeping; flush and reset both return to the empty state
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: write on push, otherwise honour squash requests on the live bit
  always_ff @(posedge CLK) begin
    // NOTE: storage is deliberately not reset; unoccupied slots are masked out by occupied.
    for (int i = 0; i < DEPTH; i++) begin
      if (push && wr_ptr == PTR_W'(i)) mem[i] <= push_entry;
      else if (clr_mask[i])            mem[i].live <= 1'b0;
    end
  end

  // A physical slot is occupied when its distance from the read pointer is below count
  always_comb begin
    logic [PTR_W-1:0] offset;
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    occupied = '0;
    offset   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset      = PTR_W'(i) - rd_ptr;
      occupied[i] = {1'b0, offset} < count;
    end
  end

  assign entries = mem;
  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU result stream (always wins) with the buffered
// long-latency stream onto the single register-file write port, squashes WAW-stale
// FIFO entries and exports the pending-destination mask used for hazard stalls.
// Optional feature macro: WB_FWD_EN adds two combinational forwarding lookup ports.
module wb_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     alu_valid,
  input  regbits_t alu_rd,
  input  word_t    alu_data,
  input  logic     lsu_valid,
  output logic     lsu_ready,
  input  regbits_t lsu_rd,
  input  word_t    lsu_data,
  input  logic     flush,
`ifdef WB_FWD_EN
  input  regbits_t fwd_rsel1,
  input  regbits_t fwd_rsel2,
  output logic     fwd_hit1,
  output logic     fwd_hit2,
  output word_t    fwd_dat1,
  output word_t    fwd_dat2,
`endif
  output logic     rf_wen,
  output regbits_t rf_wsel,
  output word_t    rf_wdat,
  output word_t    pend_mask,
  output logic [15:0] squash_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          entries [DEPTH];
  logic [DEPTH-1:0]   occupied;
  logic [DEPTH-1:0]   clr_mask;
  wb_entry_t          head;
  wb_entry_t          push_entry;
  wb_entry_t          drain_entry;
  logic               fifo_empty;
  logic               fifo_full;
  logic               alu_write;
  logic               fifo_push;
  logic               fifo_pop;
  logic [CNT_W-1:0]   squash_n;
  logic [16:0]        squash_sum;
`ifdef WB_FWD_EN
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (flush),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .clr_mask   (clr_mask),
    .entries    (entries),
    .occupied   (occupied),
    .head       (head),
    .empty      (fifo_empty),
`ifdef WB_FWD_EN
    .count      (fifo_count),
    .rd_ptr     (rd_ptr),
`else
    .count      (),
    .rd_ptr     (),
`endif
    .full       (fifo_full)
  );

  // No bypass when full: ready depends only on registered occupancy
  assign lsu_ready = ~fifo_full & ~RST;

  // Arbitration: ALU write wins; otherwise drain the head, or pass an incoming result straight through an empty FIFO
  always_comb begin
    alu_write       = alu_valid && (alu_rd != '0);
    push_entry.rd   = lsu_rd;
    push_entry.data = lsu_data;
    // x0 results and results superseded by a same-cycle ALU write are buffered dead
    push_entry.live = (lsu_rd != '0) && !(alu_write && (alu_rd == lsu_rd));
    fifo_push       = lsu_valid && lsu_ready && !flush;
    fifo_pop        = !alu_write && !flush && (!fifo_empty || fifo_push);
    drain_entry     = fifo_empty ? push_entry : head;
  end

  // WAW squash: kill every live buffered result aimed at the register the ALU is writing now
  always_comb begin
    clr_mask = '0;
    squash_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      clr_mask[i] = alu_write && occupied[i] && entries[i].live && (entries[i].rd == alu_rd);
      squash_n    = squash_n + CNT_W'(clr_mask[i]);
    end
    squash_sum = {1'b0, squash_cnt} + 17'(squash_n);
  end

  // Registered write port: one-cycle rf_wen pulse, select/data held until the next write
  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_wen  <= 1'b0;
      rf_wsel <= '0;
      rf_wdat <= '0;
    end else if (alu_write) begin
      rf_wen  <= 1'b1;
      rf_wsel <= alu_rd;
      rf_wdat <= alu_data;
    end else if (fifo_pop && drain_entry.live) begin
      rf_wen  <= 1'b1;
      rf_wsel <= drain_entry.rd;
      rf_wdat <= drain_entry.data;
    end else begin
      rf_wen  <= 1'b0;
    end
  end

  // Saturating count of entries killed by WAW squash
  always_ff @(posedge CLK) begin
    if (RST)                squash_cnt <= '0;
    else if (squash_sum[16]) squash_cnt <= 16'hFFFF;
    else                    squash_cnt <= squash_sum[15:0];
  end

  // Pending-destination mask: OR of one-hot rd over live occupied entries
  always_comb begin
    pend_mask = '0;
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occupied[i] && entries[i].live) pend_mask = pend_mask | reg_onehot(entries[i].rd);
      end
    end
  end

`ifdef WB_FWD_EN
  // Forwarding lookup: output register first, else youngest live FIFO entry with matching rd
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit1 = 1'b0;
    fwd_dat1 = '0;
    fwd_hit2 = 1'b0;
    fwd_dat2 = '0;
    idx      = '0;
    // Walk oldest to youngest so the youngest match overwrites older ones
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < fifo_count && entries[idx].live) begin
        if (entries[idx].rd == fwd_rsel1) begin
          fwd_hit1 = 1'b1;
          fwd_dat1 = entries[idx].data;
        end
        if (entries[idx].rd == fwd_rsel2) begin
          fwd_hit2 = 1'b1;
          fwd_dat2 = entries[idx].data;
        end
      end
    end
    if (rf_wen && rf_wsel == fwd_rsel1) begin
      fwd_hit1 = 1'b1;
      fwd_dat1 = rf_wdat;
    end
    if (rf_wen && rf_wsel == fwd_rsel2) begin
      fwd_hit2 = 1'b1;
      fwd_dat2 = rf_wdat;
    end
    // x0 is hardwired and never forwarded
    if (fwd_rsel1 == '0) begin
      fwd_hit1 = 1'b0;
      fwd_dat1 = '0;
    end
    if (fwd_rsel2 == '0) begin
      fwd_hit2 = 1'b0;
      fwd_dat2 = '0;
    end
  end
`endif

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that drives the single write port of the CPU register file. It merges a single-cycle ALU result stream with a long-latency (load/mul/div) result stream that uses a valid/ready handshake. Long-latency results go through a small FIFO, and the arbiter presents at most one registered write per cycle on the `register_file_if` writer signals. It sits between the execute/memory stages and the register file, and exports a pending-destination mask that decode uses for hazard stalls.

## Interface
Parameters:
- `DEPTH`, default 4: long-latency FIFO entries, power of two, ≥ 2.

Ports:
- `CLK`  in  1  clock; all state updates on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle. No backpressure: always accepted.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32 (`word_t`)  ALU result.
- `lsu_valid`  in  1  long-latency result offered.
- `lsu_ready`  out  1  arbiter can accept a long-latency result.
- `lsu_rd`  in  5  long-latency destination register.
- `lsu_data`  in  32  long-latency result.
- `flush`  in  1  discard all buffered long-latency results.
- `rf_wen`  out  1  register-file write enable.
- `rf_wsel`  out  5  register-file write select.
- `rf_wdat`  out  32  register-file write data.
- `pend_mask`  out  32  bit r set while any live FIFO entry targets register r.
- `squash_cnt`  out  16  count of FIFO entries killed by WAW squash; saturating.

## Operation
- **ALU priority.** An ALU result with `alu_valid=1` and `alu_rd≠0` is always written in the next cycle.
- **FIFO drain.** The FIFO head drains only in cycles where the ALU is not writing (`alu_valid=0` or `alu_rd=0`).
- **Enqueue.** A long-latency result is accepted when `lsu_valid & lsu_ready`.
  - `lsu_ready = ~full & ~RST`.
  - There is no enqueue-while-full bypass: when full, `lsu_ready` stays low even if the head drains that cycle.
- **Writes to x0.** These are never issued (`rf_wen` stays 0).
  - An ALU result to x0 is treated as no ALU write.
  - An LSU result to x0 is accepted but enqueued with its live bit cleared.
- **Dead entries.** A dead entry (live bit 0) at the head is popped without asserting `rf_wen`. It uses a drain slot.
- **WAW squash.** When an ALU write to `alu_rd≠0` occurs, every live FIFO entry with `rd == alu_rd` has its live bit cleared in the same posedge, and `squash_cnt` increments by the number cleared (saturating at 0xFFFF).
  - An LSU result enqueued in the same cycle as an ALU write to the same register is enqueued dead, because the ALU result is the newer one.
- **`pend_mask`.** This is the OR of one-hot decodes of every live entry's `rd`. It is computed combinationally from FIFO state.
- **Flush.** `flush=1` empties the FIFO (count 0, pointers 0).
  - Any enqueue in that cycle is dropped.
  - An ALU write in that cycle still occurs.
  - The output register is unaffected.
- **FIFO state.** Read/write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. `count` is `log2(DEPTH)+1` bits. Simultaneous push and pop leave `count` unchanged.

## Timing
- **Reset values.** All outputs are 0 during and immediately after reset: `rf_wen`, `rf_wsel`, `rf_wdat`, `pend_mask`, `squash_cnt`, `lsu_ready`. `lsu_ready` rises in the first cycle with `RST=0`.
- **ALU latency.** ALU result at posedge N appears on `rf_*` during cycle N+1.
- **LSU latency.** Minimum is 1 cycle: accepted at edge N with an empty FIFO and no ALU write in cycle N gives `rf_wen` in cycle N+1 (same-cycle push+pop through an empty FIFO is allowed).
- **Register-file timing.** The register file samples on the negedge, so `rf_*` are registered and held stable for the whole cycle. `rf_wen` is a one-cycle pulse per write.
- **Reset mid-operation.** The FIFO empties and the in-flight output write is cancelled at that edge. Dropped results are not reported.
- **Starvation.** Continuous ALU writes starve the FIFO indefinitely. Upstream accepts this through `lsu_ready` backpressure.

## Configuration
- **`WB_FWD_EN` defined.** Adds forwarding ports:
  - Inputs: `fwd_rsel1`, `fwd_rsel2` (5 each).
  - Outputs per port: `fwd_hit1`, `fwd_hit2` (1) and `fwd_dat1`, `fwd_dat2` (32).
  - Lookup is combinational and prioritised: the current `rf_*` output register first, then the youngest live FIFO entry with matching `rd`.
  - `rsel=0` never hits.
- **`WB_FWD_EN` undefined.** The ports and lookup logic are absent. Decode relies on `pend_mask` stalls only.

## Structure
- **Package.** `word_t` and `regbits_t` (5-bit register index) live in `cpu_types_pkg`. Add to it:
  - `wb_entry_t` struct: `live`, `rd`, `data`.
  - Constant `WB_DEPTH_DEFAULT = 4`.
- **Sub-module `wb_fifo`.**
  - Holds storage, pointers and count.
  - Exposes an entry-array view and a per-entry live-clear mask input, used for squash and `pend_mask`.
  - `wb_arbiter` holds arbitration, the output register and the counters.

## Test plan
- **ALU vs LSU conflict.** Reset, then `alu_valid` with rd=5, data=0x11 and simultaneously LSU rd=6, data=0x22. Required response:
  - Next cycle: `rf_wen=1`, `wsel=5`, `wdat=0x11`.
  - Following cycle: `wsel=6`, `wdat=0x22`.
  - `pend_mask[6]` is high in between.
- **FIFO full / backpressure.** Hold `alu_valid` (rd=1) continuously and push 4 LSU results. Required response: `lsu_ready=0` after the 4th accept. Release ALU; the 4 LSU writes then occur in order on consecutive cycles.
- **WAW squash.** Enqueue LSU rd=7 while ALU is busy, then ALU writes rd=7, data=0xAA. Required response:
  - `pend_mask[7]` clears.
  - `squash_cnt=1`.
  - No later write to register 7 occurs.
- **x0 suppression.** ALU rd=0 data=0xFF, then LSU rd=0. Required response: `rf_wen` never asserts and `pend_mask=0`.
- **Flush and reset mid-operation.** Fill the FIFO with 3 entries, then assert `flush` together with ALU rd=2. Required response: only the rd=2 write occurs and `count=0`. Repeat with `RST` instead of `flush`: all outputs read 0.
- **Forwarding (`WB_FWD_EN`).** Two FIFO entries rd=9 (data 0x1 then 0x2), with `fwd_rsel1=9`. Required response: `fwd_hit1=1`, `fwd_dat1=0x2`.
